// File: rtl/clock_period_meter_if.sv
// Bundle carrying the measured divided clock and the resulting period/high-time report.
// The meter is the slave end; whoever supplies sig_in and consumes the report is the master.
interface clock_period_meter_if #(
   parameter int SIZE = 28
);
   logic            sig_in;
   logic [SIZE-1:0] period;
   logic [SIZE-1:0] high_time;
   logic            valid;
   logic            timeout;

   modport master (
      output sig_in,
      input  period,
      input  high_time,
      input  valid,
      input  timeout
   );

   modport slave (
      input  sig_in,
      output period,
      output high_time,
      output valid,
      output timeout
   );
endinterface

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow divided clock sampled in the clk_in domain,
// reporting once per period, with a timeout for stopped or too-slow inputs.
module clock_period_meter #(
   parameter int          SIZE    = 28,
   parameter int unsigned TIMEOUT = 250_000_000
) (
   input logic                 clk_in,
   input logic                 rst,
   clock_period_meter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      MEASURE
   } state_t;

   localparam logic [SIZE-1:0] CNT_LAST = SIZE'(TIMEOUT - 1);

   state_t          state_reg;
   state_t          state_next;

   logic            s1;
   logic            s2;
   logic            s_prev;
   logic [1:0]      fill;
   logic            primed;
   logic            rise;
   logic            fall;

   logic [SIZE-1:0] cnt;
   logic [SIZE-1:0] hi_cap;
   logic [SIZE-1:0] period_reg;
   logic [SIZE-1:0] high_time_reg;
   logic            valid_reg;
   logic            timeout_reg;

   logic            start;
   logic            report;
   logic            expire;
   logic            capture;

   assign rise   = s2 & ~s_prev;
   assign fall   = ~s2 & s_prev;
   // s2 only reflects a real sample two edges after reset; before that its
   // zero is an artefact, and trusting it would arm on an input already high.
   assign primed = fill[1];

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      start      = 1'b0;
      report     = 1'b0;
      expire     = 1'b0;
      capture    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (primed && !s2) begin
               state_next = ARMED;
            end
         end
         ARMED: begin
            if (rise) begin
               state_next = MEASURE;
               start      = 1'b1;
            end
         end
         MEASURE: begin
            capture = fall;
            // A rise on the last counted cycle is still a measurement.
            if (rise) begin
               report = 1'b1;
            end else if (cnt == CNT_LAST) begin
               expire     = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         s1            <= 1'b0;
         s2            <= 1'b0;
         s_prev        <= 1'b0;
         fill          <= 2'b00;
         cnt           <= '0;
         hi_cap        <= '0;
         period_reg    <= '0;
         high_time_reg <= '0;
         valid_reg     <= 1'b0;
         timeout_reg   <= 1'b0;
      end else begin
         s1        <= bus.sig_in;
         s2        <= s1;
         s_prev    <= s2;
         fill      <= {fill[0], 1'b1};
         valid_reg <= 1'b0;

         if (start || report || expire) begin
            cnt <= '0;
         end else if (state_reg == MEASURE) begin
            cnt <= cnt + SIZE'(1);
         end

         if (capture) begin
            hi_cap <= cnt + SIZE'(1);
         end

         if (report) begin
            period_reg    <= cnt + SIZE'(1);
            high_time_reg <= hi_cap;
            valid_reg     <= 1'b1;
            timeout_reg   <= 1'b0;
         end else if (expire) begin
            timeout_reg <= 1'b1;
         end
      end
   end

   assign bus.period    = period_reg;
   assign bus.high_time = high_time_reg;
   assign bus.valid     = valid_reg;
   assign bus.timeout   = timeout_reg;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter (SIZE=8, TIMEOUT=100): square waves of known
// duty, reset corner cases and timeout behaviour, with hand-computed expectations.
module tb_clock_period_meter;

   logic clk_in = 1'b0;
   logic rst    = 1'b1;

   clock_period_meter_if #(.SIZE(8)) bus ();

   clock_period_meter #(
      .SIZE   (8),
      .TIMEOUT(100)
   ) dut (
      .clk_in(clk_in),
      .rst   (rst),
      .bus   (bus)
   );

   always #5 clk_in = ~clk_in;

   int   passed  = 0;
   int   total   = 0;
   int   step_n  = 0;
   int   to_rise = -1;
   int   to_last = -1;
   logic to_prev = 1'b0;
   int   v_step[$];
   int   v_per[$];
   int   v_hi[$];

   // One clock: sample just after the edge, log valid/timeout events, then drive.
   task automatic step(input logic v, input logic r);
      @(posedge clk_in);
      #1;
      if (bus.valid === 1'b1) begin
         v_step.push_back(step_n);
         v_per.push_back(int'(bus.period));
         v_hi.push_back(int'(bus.high_time));
      end
      if (bus.timeout === 1'b1) begin
         if (!to_prev && to_rise < 0) to_rise = step_n;
         to_last = step_n;
      end
      to_prev    = bus.timeout;
      bus.sig_in = v;
      rst        = r;
      step_n++;
   endtask

   task automatic clear_log();
      step_n  = 0;
      to_rise = -1;
      to_last = -1;
      to_prev = bus.timeout;
      v_step.delete();
      v_per.delete();
      v_hi.delete();
   endtask

   task automatic wave(input int hi, input int lo, input int reps);
      for (int r = 0; r < reps; r++)
         for (int i = 0; i < hi + lo; i++) step(i < hi, 1'b0);
   endtask

   task automatic do_reset(input logic v);
      repeat (3) step(v, 1'b1);
      step(v, 1'b0);
   endtask

   task automatic test_reset();
      bus.sig_in = 1'b0;
      do_reset(1'b0);
      total++; if (bus.valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.valid); else passed++;
      total++; if (bus.timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", bus.timeout); else passed++;
      total++; if (bus.period !== 8'd0) $display("FAIL reset_period: got %0d want 0", bus.period); else passed++;
      total++; if (bus.high_time !== 8'd0) $display("FAIL reset_high_time: got %0d want 0", bus.high_time); else passed++;
   endtask

   task automatic test_square_wave();
      int first;
      clear_log();
      wave(10, 10, 5);
      first = (v_step.size() > 0) ? v_step[0] : -1;
      total++; if (v_step.size() !== 4) $display("FAIL sq_count: got %0d want 4", v_step.size()); else passed++;
      total++; if (first !== 23) $display("FAIL sq_first_step: got %0d want 23", first); else passed++;
      for (int i = 0; i < v_step.size(); i++) begin
         total++; if (v_per[i] !== 20) $display("FAIL sq_period[%0d]: got %0d want 20", i, v_per[i]); else passed++;
         total++; if (v_hi[i] !== 10) $display("FAIL sq_high[%0d]: got %0d want 10", i, v_hi[i]); else passed++;
         if (i > 0) begin
            total++;
            if (v_step[i] - v_step[i-1] !== 20) $display("FAIL sq_interval[%0d]: got %0d want 20", i, v_step[i] - v_step[i-1]);
            else passed++;
         end
      end
      total++; if (to_rise !== -1) $display("FAIL sq_timeout: rose at step %0d want never", to_rise); else passed++;
   endtask

   task automatic test_duty_change();
      clear_log();
      wave(3, 7, 5);
      total++; if (v_step.size() !== 5) $display("FAIL duty_count: got %0d want 5", v_step.size()); else passed++;
      if (v_step.size() > 0) begin
         total++; if (v_per[0] !== 20 || v_hi[0] !== 10) $display("FAIL duty_transition: got %0d/%0d want 20/10", v_per[0], v_hi[0]); else passed++;
      end
      for (int i = 1; i < v_step.size(); i++) begin
         total++; if (v_per[i] !== 10 || v_hi[i] !== 3) $display("FAIL duty_3_7[%0d]: got %0d/%0d want 10/3", i, v_per[i], v_hi[i]); else passed++;
      end
   endtask

   task automatic test_back_to_back();
      clear_log();
      wave(1, 1, 20);
      total++; if (v_step.size() !== 19) $display("FAIL b2b_count: got %0d want 19", v_step.size()); else passed++;
      if (v_step.size() > 0) begin
         total++; if (v_per[0] !== 10 || v_hi[0] !== 3) $display("FAIL b2b_transition: got %0d/%0d want 10/3", v_per[0], v_hi[0]); else passed++;
      end
      for (int i = 1; i < v_step.size(); i++) begin
         total++; if (v_per[i] !== 2 || v_hi[i] !== 1) $display("FAIL b2b_min[%0d]: got %0d/%0d want 2/1", i, v_per[i], v_hi[i]); else passed++;
         total++; if (v_step[i] - v_step[i-1] !== 2) $display("FAIL b2b_interval[%0d]: got %0d want 2", i, v_step[i] - v_step[i-1]); else passed++;
      end
   endtask

   task automatic test_high_at_reset();
      int first;
      bus.sig_in = 1'b1;
      do_reset(1'b1);
      clear_log();
      repeat (10) step(1'b1, 1'b0);
      total++; if (v_step.size() !== 0) $display("FAIL hr_hold_no_valid: got %0d want 0", v_step.size()); else passed++;
      wave(5, 5, 6);
      first = (v_step.size() > 0) ? v_step[0] : -1;
      total++; if (v_step.size() !== 4) $display("FAIL hr_count: got %0d want 4", v_step.size()); else passed++;
      total++; if (first !== 33) $display("FAIL hr_first_step: got %0d want 33", first); else passed++;
      for (int i = 0; i < v_step.size(); i++) begin
         total++; if (v_per[i] !== 10 || v_hi[i] !== 5) $display("FAIL hr_value[%0d]: got %0d/%0d want 10/5", i, v_per[i], v_hi[i]); else passed++;
      end
   endtask

   task automatic test_timeout();
      int last;
      int first;
      bus.sig_in = 1'b0;
      do_reset(1'b0);
      clear_log();
      wave(10, 10, 4);
      repeat (110) step(1'b0, 1'b0);
      last = (v_step.size() > 2) ? v_step[2] : -1;
      total++; if (v_step.size() !== 3) $display("FAIL to_count: got %0d want 3", v_step.size()); else passed++;
      total++; if (last !== 63) $display("FAIL to_last_valid: got %0d want 63", last); else passed++;
      total++; if (to_rise !== 163) $display("FAIL to_rise_step: got %0d want 163", to_rise); else passed++;
      total++; if (bus.timeout !== 1'b1) $display("FAIL to_level: got %b want 1", bus.timeout); else passed++;
      total++; if (bus.period !== 8'd20) $display("FAIL to_period_held: got %0d want 20", bus.period); else passed++;
      total++; if (bus.high_time !== 8'd10) $display("FAIL to_high_held: got %0d want 10", bus.high_time); else passed++;

      clear_log();
      wave(10, 10, 3);
      first = (v_step.size() > 0) ? v_step[0] : -1;
      total++; if (v_step.size() !== 2) $display("FAIL to_resume_count: got %0d want 2", v_step.size()); else passed++;
      total++; if (first !== 23) $display("FAIL to_resume_first: got %0d want 23", first); else passed++;
      total++; if (to_last !== 22) $display("FAIL to_clear_step: last high %0d want 22", to_last); else passed++;
      if (v_step.size() > 0) begin
         total++; if (v_per[0] !== 20 || v_hi[0] !== 10) $display("FAIL to_resume_value: got %0d/%0d want 20/10", v_per[0], v_hi[0]); else passed++;
      end
   endtask

   task automatic test_reset_mid_period();
      int first;
      bus.sig_in = 1'b0;
      do_reset(1'b0);
      clear_log();
      wave(10, 10, 3);
      repeat (5) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      total++; if (bus.valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", bus.valid); else passed++;
      total++; if (bus.timeout !== 1'b0) $display("FAIL mid_timeout: got %b want 0", bus.timeout); else passed++;
      total++; if (bus.period !== 8'd0) $display("FAIL mid_period: got %0d want 0", bus.period); else passed++;
      total++; if (bus.high_time !== 8'd0) $display("FAIL mid_high_time: got %0d want 0", bus.high_time); else passed++;

      clear_log();
      repeat (3) step(1'b1, 1'b0);
      repeat (2) begin
         repeat (10) step(1'b0, 1'b0);
         repeat (10) step(1'b1, 1'b0);
      end
      repeat (10) step(1'b0, 1'b0);
      first = (v_step.size() > 0) ? v_step[0] : -1;
      total++; if (v_step.size() !== 1) $display("FAIL mid_after_count: got %0d want 1", v_step.size()); else passed++;
      total++; if (first !== 36) $display("FAIL mid_after_step: got %0d want 36", first); else passed++;
      if (v_step.size() > 0) begin
         total++; if (v_per[0] !== 20 || v_hi[0] !== 10) $display("FAIL mid_after_value: got %0d/%0d want 20/10", v_per[0], v_hi[0]); else passed++;
      end
   endtask

   task automatic test_period_equals_timeout();
      bus.sig_in = 1'b0;
      do_reset(1'b0);
      clear_log();
      wave(50, 50, 3);
      total++; if (v_step.size() !== 2) $display("FAIL edge_count: got %0d want 2", v_step.size()); else passed++;
      for (int i = 0; i < v_step.size(); i++) begin
         total++; if (v_step[i] !== 103 + 100 * i) $display("FAIL edge_step[%0d]: got %0d want %0d", i, v_step[i], 103 + 100 * i); else passed++;
         total++; if (v_per[i] !== 100 || v_hi[i] !== 50) $display("FAIL edge_value[%0d]: got %0d/%0d want 100/50", i, v_per[i], v_hi[i]); else passed++;
      end
      total++; if (to_rise !== -1) $display("FAIL edge_timeout: rose at step %0d want never", to_rise); else passed++;
   endtask

   initial begin
      bus.sig_in = 1'b0;
      test_reset();
      test_square_wave();
      test_duty_change();
      test_back_to_back();
      test_high_at_reset();
      test_timeout();
      test_reset_mid_period();
      test_period_equals_timeout();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/clock_period_meter.md
# clock_period_meter

Measures the slow clock produced by the team's divider blocks: it samples a divided clock as an ordinary signal in the fast `clk_in` domain, and reports its period and high time in `clk_in` cycles once per period. It sits at the consuming end of a divided clock, for self-check of divider settings and for driving the 7-segment readout. A timeout flags a stopped or too-slow input.

## Interface
- `SIZE`, 28: width of the internal counter and of `period` / `high_time`.
- `TIMEOUT`, 28'd250000000: cycles without a detected rising edge before `timeout` is raised.
  - Constraint: 4 <= TIMEOUT < 2^SIZE.
- `clk_in`  input  1  sole clock; all logic on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `sig_in`  input  1  divided clock under measurement; asynchronous to `clk_in`.
- `period`  output  SIZE  `clk_in` cycles between the last two detected rising edges.
- `high_time`  output  SIZE  `clk_in` cycles between that first rising edge and the following falling edge.
- `valid`  output  1  one-cycle pulse when `period` / `high_time` update.
- `timeout`  output  1  level; set on timeout, cleared on next `valid`.

## Operation
- Synchronizer: two flops `s1` → `s2`, then `s_prev <= s2`.
  - rise = s2 & ~s_prev.
  - fall = ~s2 & s_prev.
- Counter `cnt` (SIZE bits) and capture register `hi_cap` (SIZE bits).
- FSM states:
  - IDLE: wait for s2 == 0, then go to ARMED. This prevents a false edge from a signal already high at reset release.
  - ARMED: on rise, set cnt <= 0 and go to MEASURE. No `valid` here.
  - MEASURE: cnt <= cnt + 1 every cycle, except:
    - On fall: hi_cap <= cnt + 1.
    - On rise: period <= cnt + 1, high_time <= hi_cap, valid <= 1, timeout <= 0, cnt <= 0. Stay in MEASURE.
    - If cnt == TIMEOUT-1 with no rise this cycle: timeout <= 1, cnt <= 0, go to IDLE. `period` and `high_time` hold their old values.
- A rise in the same cycle that cnt == TIMEOUT-1 counts as a rise; measurement wins and there is no timeout.
- `cnt` never exceeds TIMEOUT-1, so there is no wrap-around.
- Falls seen in IDLE or ARMED are ignored. `hi_cap` holds its last value.
- `valid` is cleared every cycle it is not set.

## Timing
- Reset, synchronous: rst high at an edge forces the following at that edge.
  - `s1`, `s2`, `s_prev`, `cnt`, `hi_cap`, `period`, `high_time`, `valid`, `timeout` all = 0.
  - State = IDLE.
  - Reset mid-measurement discards the partial count; no `valid` is produced.
- Edge latency:
  - `sig_in` first captured high at edge k → s2 high after edge k+1 → rise is true in the cycle after edge k+1.
  - `valid` and the new `period` are visible after edge k+2: 3 edges from first capture.
- Example: a synchronized square wave with N cycles high and M cycles low gives period = N+M and high_time = N.
  - Minimum measurable: N = M = 1 → period 2, high_time 1.
- First `valid` after reset comes on the second detected rising edge after the input has been seen low.
- `timeout` rises TIMEOUT cycles after the last rise was detected, if no rise followed.
- After a timeout, `valid` resumes only after: input seen low, then one rise to arm, then a second rise.

## Test plan
Use SIZE=8, TIMEOUT=100 unless stated.
- Reset, then `sig_in` 10 high / 10 low repeated → first `valid` on the 2nd detected rise with period=20, high_time=10. `valid` then pulses every 20 cycles; `timeout`=0 throughout.
- 3 high / 7 low duty → period=10, high_time=3. Then 1 high / 1 low → period=2, high_time=1.
- `sig_in` held high before and through reset release, later 5 high / 5 low → no `valid` until the 2nd rise after the first low. First report is period=10, high_time=5 (no short false measurement).
- After several 20-cycle periods, `sig_in` frozen → `timeout` rises exactly 100 cycles after the last rise was detected. period=20 and high_time=10 are retained with no `valid`. On resuming, `timeout` stays 1 until the next `valid`, and clears in that same cycle.
- rst pulsed for 1 cycle mid-period → all outputs 0 at the next edge with state IDLE. The next `valid` requires low, rise, then rise.
- Period of exactly TIMEOUT (50/50 with TIMEOUT=100) → rise coincides with cnt==99: `valid` with period=100, `timeout` stays 0.
